// File: rtl/mem_test.sv
// Two-memory test block: mem_a held here, mem_b in u_mem_b/u_sram, with a shadow
// port over one global byte-address map that exists only when LOOM_SHADOW_EN is defined.

module mem_test_sram #(
    parameter int DW = 16,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          i_we0,
    input  logic [AW-1:0] i_addr0,
    input  logic [DW-1:0] i_wdata0,
    output logic [DW-1:0] o_rdata0,
    input  logic          i_we1,
    input  logic [AW-1:0] i_addr1,
    input  logic [DW-1:0] i_wdata1,
    output logic [DW-1:0] o_rdata1
);
    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    // Port 1 is written last so it wins when both ports hit the same word
    always_ff @(posedge clk) begin
        if (i_we0) r_mem[i_addr0] <= i_wdata0;
        if (i_we1) r_mem[i_addr1] <= i_wdata1;
    end

    assign o_rdata0 = r_mem[i_addr0];
    assign o_rdata1 = r_mem[i_addr1];
endmodule

module mem_test_mem_b (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_we,
    input  logic [5:0]  i_addr,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    input  logic        i_sh_we,
    input  logic [5:0]  i_sh_addr,
    input  logic [15:0] i_sh_wdata,
    output logic [15:0] o_sh_rdata
);
    logic [15:0] w_rdata;
    logic [15:0] r_rdata;

    mem_test_sram #(.DW(16), .AW(6)) u_sram (
        .clk      (clk),
        .i_we0    (i_we),
        .i_addr0  (i_addr),
        .i_wdata0 (i_wdata),
        .o_rdata0 (w_rdata),
        .i_we1    (i_sh_we),
        .i_addr1  (i_sh_addr),
        .i_wdata1 (i_sh_wdata),
        .o_rdata1 (o_sh_rdata)
    );

    // Functional read register: old contents on read-during-write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rdata <= 16'h0000;
        else        r_rdata <= w_rdata;
    end

    assign o_rdata = r_rdata;
endmodule

module mem_test #(
    parameter int                   SHADOW_AW  = 11,
    parameter int                   SHADOW_DW  = 16,
    parameter logic [SHADOW_AW-1:0] MEM_B_BASE = 11'h000,
    parameter logic [SHADOW_AW-1:0] MEM_A_BASE = 11'h100
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_a_we,
    input  logic [7:0]           mem_a_addr,
    input  logic [7:0]           mem_a_wdata,
    output logic [7:0]           mem_a_rdata,
    input  logic                 mem_b_we,
    input  logic [5:0]           mem_b_addr,
    input  logic [15:0]          mem_b_wdata,
    output logic [15:0]          mem_b_rdata,
    input  logic [SHADOW_AW-1:0] loom_shadow_addr,
    input  logic [SHADOW_DW-1:0] loom_shadow_wdata,
    output logic [SHADOW_DW-1:0] loom_shadow_rdata,
    input  logic                 loom_shadow_wen,
    input  logic                 loom_shadow_ren
);
    localparam logic [SHADOW_AW-1:0] MEM_B_SIZE = 11'h100;
    localparam logic [SHADOW_AW-1:0] MEM_A_SIZE = 11'h400;

    logic [7:0]           r_mem_a [0:255];
    logic [7:0]           r_mem_a_rdata;
    logic [SHADOW_AW-1:0] w_a_off;
    logic [SHADOW_AW-1:0] w_b_off;
    logic                 w_sel_a;
    logic                 w_sel_b;
    logic [7:0]           w_sh_a_idx;
    logic [5:0]           w_sh_b_idx;
    logic                 w_sh_wen_a;
    logic                 w_sh_wen_b;
    logic [15:0]          w_b_sh_rdata;
    logic                 w_unused_off;
    logic                 w_unused_sh;

    // Addresses below a base wrap to a large offset, so one compare per region suffices
    assign w_a_off    = loom_shadow_addr - MEM_A_BASE;
    assign w_b_off    = loom_shadow_addr - MEM_B_BASE;
    assign w_sel_a    = (w_a_off < MEM_A_SIZE);
    assign w_sel_b    = (w_b_off < MEM_B_SIZE);
    assign w_sh_a_idx = w_a_off[9:2];
    assign w_sh_b_idx = w_b_off[7:2];
    assign w_unused_off = ^{w_a_off[SHADOW_AW-1:10], w_a_off[1:0],
                            w_b_off[SHADOW_AW-1:8], w_b_off[1:0]};

    // mem_a array; the shadow write is last so it wins a same-word collision
    always_ff @(posedge clk) begin
        if (mem_a_we)   r_mem_a[mem_a_addr] <= mem_a_wdata;
        if (w_sh_wen_a) r_mem_a[w_sh_a_idx] <= loom_shadow_wdata[7:0];
    end

    // mem_a functional read register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_mem_a_rdata <= 8'h00;
        else        r_mem_a_rdata <= r_mem_a[mem_a_addr];
    end

    assign mem_a_rdata = r_mem_a_rdata;

    mem_test_mem_b u_mem_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (mem_b_we),
        .i_addr     (mem_b_addr),
        .i_wdata    (mem_b_wdata),
        .o_rdata    (mem_b_rdata),
        .i_sh_we    (w_sh_wen_b),
        .i_sh_addr  (w_sh_b_idx),
        .i_sh_wdata (loom_shadow_wdata[15:0]),
        .o_sh_rdata (w_b_sh_rdata)
    );

`ifdef LOOM_SHADOW_EN
    logic [15:0]          w_sh_rd;
    logic [SHADOW_DW-1:0] r_shadow_rdata;

    assign w_sh_wen_a  = loom_shadow_wen & w_sel_a;
    assign w_sh_wen_b  = loom_shadow_wen & w_sel_b;
    assign w_unused_sh = 1'b0;

    // Selected word zero-extended; unmapped addresses read as zero
    always_comb begin
        w_sh_rd = 16'h0000;
        if (w_sel_a)      w_sh_rd = {8'h00, r_mem_a[w_sh_a_idx]};
        else if (w_sel_b) w_sh_rd = w_b_sh_rdata;
        else              w_sh_rd = 16'h0000;
    end

    // Shadow read register holds while ren is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               r_shadow_rdata <= 16'h0000;
        else if (loom_shadow_ren) r_shadow_rdata <= w_sh_rd;
        else                      r_shadow_rdata <= r_shadow_rdata;
    end

    assign loom_shadow_rdata = r_shadow_rdata;
`else
    assign w_sh_wen_a        = 1'b0;
    assign w_sh_wen_b        = 1'b0;
    assign loom_shadow_rdata = 16'h0000;
    assign w_unused_sh = ^{loom_shadow_wen, loom_shadow_ren, w_sel_a, w_sel_b, w_b_sh_rdata};
`endif
endmodule

// File: tb/tb_mem_test.sv
// Randomized self-checking bench for mem_test against an array-level reference model;
// adapts its shadow expectations to whether LOOM_SHADOW_EN is defined.

module tb_mem_test;
`ifdef LOOM_SHADOW_EN
    localparam bit SH_EN = 1'b1;
`else
    localparam bit SH_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_a_we = 1'b0;
    logic [7:0]  mem_a_addr = 8'h00;
    logic [7:0]  mem_a_wdata = 8'h00;
    logic [7:0]  mem_a_rdata;
    logic        mem_b_we = 1'b0;
    logic [5:0]  mem_b_addr = 6'h00;
    logic [15:0] mem_b_wdata = 16'h0000;
    logic [15:0] mem_b_rdata;
    logic [10:0] loom_shadow_addr = 11'h000;
    logic [15:0] loom_shadow_wdata = 16'h0000;
    logic [15:0] loom_shadow_rdata;
    logic        loom_shadow_wen = 1'b0;
    logic        loom_shadow_ren = 1'b0;

    logic [7:0]  ma [256];
    logic [15:0] mb [64];
    logic [15:0] exp_a = 16'h0000;
    logic [15:0] exp_b = 16'h0000;
    logic [15:0] exp_sh = 16'h0000;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          chk_on = 1'b0;

    mem_test dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mem_a_we          (mem_a_we),
        .mem_a_addr        (mem_a_addr),
        .mem_a_wdata       (mem_a_wdata),
        .mem_a_rdata       (mem_a_rdata),
        .mem_b_we          (mem_b_we),
        .mem_b_addr        (mem_b_addr),
        .mem_b_wdata       (mem_b_wdata),
        .mem_b_rdata       (mem_b_rdata),
        .loom_shadow_addr  (loom_shadow_addr),
        .loom_shadow_wdata (loom_shadow_wdata),
        .loom_shadow_rdata (loom_shadow_rdata),
        .loom_shadow_wen   (loom_shadow_wen),
        .loom_shadow_ren   (loom_shadow_ren)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input int a);
        if (a < 256)         return mb[a / 4];
        else if (a < 'h500)  return {8'h00, ma[(a - 256) / 4]};
        else                 return 16'h0000;
    endfunction

    task automatic model_write(input int a, input logic [15:0] d);
        if (a < 256)        mb[a / 4] = d;
        else if (a < 'h500) ma[(a - 256) / 4] = d[7:0];
    endtask

    // One clock: predict from pre-edge model state, apply writes (shadow last), compare
    task automatic tick();
        exp_a = {8'h00, ma[mem_a_addr]};
        exp_b = mb[mem_b_addr];
        if (SH_EN && loom_shadow_ren) exp_sh = model_read(int'(loom_shadow_addr));
        if (mem_a_we) ma[mem_a_addr] = mem_a_wdata;
        if (mem_b_we) mb[mem_b_addr] = mem_b_wdata;
        if (SH_EN && loom_shadow_wen) model_write(int'(loom_shadow_addr), loom_shadow_wdata);
        @(posedge clk);
        @(negedge clk);
        if (chk_on) begin
            check("a_rdata", {8'h00, mem_a_rdata}, exp_a);
            check("b_rdata", mem_b_rdata, exp_b);
            check("sh_rdata", loom_shadow_rdata, exp_sh);
        end
    endtask

    task automatic idle();
        mem_a_we = 1'b0;
        mem_b_we = 1'b0;
        loom_shadow_wen = 1'b0;
        loom_shadow_ren = 1'b0;
    endtask

    task automatic sh_rd(input logic [10:0] a);
        idle();
        loom_shadow_addr = a;
        loom_shadow_ren = 1'b1;
        tick();
    endtask

    task automatic sh_wr(input logic [10:0] a, input logic [15:0] d);
        idle();
        loom_shadow_addr = a;
        loom_shadow_wdata = d;
        loom_shadow_wen = 1'b1;
        tick();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_a", {8'h00, mem_a_rdata}, 16'h0000);
        check("rst_b", mem_b_rdata, 16'h0000);
        check("rst_sh", loom_shadow_rdata, 16'h0000);
        rst_n = 1'b1;

        // Fill both arrays so every later read has a known value
        for (int i = 0; i < 256; i++) begin
            mem_a_we = 1'b1;
            mem_a_addr = 8'(i);
            mem_a_wdata = 8'($urandom);
            mem_b_we = (i < 64);
            mem_b_addr = 6'(i);
            mem_b_wdata = 16'($urandom);
            tick();
        end
        idle();
        tick();
        chk_on = 1'b1;

        mem_a_we = 1'b1;
        mem_a_addr = 8'h10; mem_a_wdata = 8'hAB; tick();
        mem_a_addr = 8'h20; mem_a_wdata = 8'hCD; tick();
        mem_a_addr = 8'h30; mem_a_wdata = 8'hEF; tick();
        sh_rd(11'h140); check("tp_sh140", loom_shadow_rdata, SH_EN ? 16'h00AB : 16'h0000);
        sh_rd(11'h180); check("tp_sh180", loom_shadow_rdata, SH_EN ? 16'h00CD : 16'h0000);
        sh_rd(11'h1C0); check("tp_sh1C0", loom_shadow_rdata, SH_EN ? 16'h00EF : 16'h0000);

        sh_wr(11'h200, 16'h0012);
        sh_wr(11'h240, 16'h0034);
        idle();
        mem_a_addr = 8'h40; tick();
        check("tp_a40", {8'h00, mem_a_rdata}, SH_EN ? 16'h0012 : {8'h00, ma[64]});
        mem_a_addr = 8'h50; tick();
        check("tp_a50", {8'h00, mem_a_rdata}, SH_EN ? 16'h0034 : {8'h00, ma[80]});

        mem_b_we = 1'b1;
        mem_b_addr = 6'h0A; mem_b_wdata = 16'hDEAD; tick();
        mem_b_addr = 6'h0B; mem_b_wdata = 16'hBEEF; tick();
        sh_rd(11'h028); check("tp_sh028", loom_shadow_rdata, SH_EN ? 16'hDEAD : 16'h0000);
        sh_rd(11'h02C); check("tp_sh02C", loom_shadow_rdata, SH_EN ? 16'hBEEF : 16'h0000);

        mem_a_addr = 8'h00; mem_b_addr = 6'h3E;
        sh_wr(11'h0FC, 16'hCAFE);
        mem_b_addr = 6'h3F; tick();
        check("tp_b3F", mem_b_rdata, SH_EN ? 16'hCAFE : mb[63]);

        sh_wr(11'h500, 16'h5A5A);
        sh_rd(11'h500); check("tp_unmapped", loom_shadow_rdata, 16'h0000);

        idle();
        mem_b_we = 1'b1; mem_b_addr = 6'h05; mem_b_wdata = 16'h1111;
        loom_shadow_wen = 1'b1; loom_shadow_addr = 11'h014; loom_shadow_wdata = 16'h2222;
        tick();
        idle();
        tick();
        check("tp_collide", mem_b_rdata, SH_EN ? 16'h2222 : 16'h1111);

        for (int n = 0; n < 600; n++) begin
            mem_a_we = 1'($urandom);
            mem_a_addr = 8'($urandom);
            mem_a_wdata = 8'($urandom);
            mem_b_we = 1'($urandom);
            mem_b_addr = 6'($urandom);
            mem_b_wdata = 16'($urandom);
            loom_shadow_wen = 1'($urandom);
            loom_shadow_ren = 1'($urandom);
            loom_shadow_wdata = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       loom_shadow_addr = 11'($urandom);
                1:       loom_shadow_addr = 11'(256 + 4 * int'(mem_a_addr) + $urandom_range(0, 3));
                2:       loom_shadow_addr = 11'(4 * int'(mem_b_addr) + $urandom_range(0, 3));
                default: loom_shadow_addr = 11'('h500 + $urandom_range(0, 'h2FF));
            endcase
            tick();
        end

        // Reset in the middle of a pending read
        idle();
        mem_a_addr = 8'h10; mem_b_addr = 6'h0B;
        loom_shadow_addr = 11'h140; loom_shadow_ren = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_a", {8'h00, mem_a_rdata}, 16'h0000);
        check("midrst_b", mem_b_rdata, 16'h0000);
        check("midrst_sh", loom_shadow_rdata, 16'h0000);
        @(negedge clk);
        check("rsthold_sh", loom_shadow_rdata, 16'h0000);
        rst_n = 1'b1;
        exp_sh = 16'h0000;

        // Sweep every word and the whole shadow map, including unmapped space
        for (int i = 0; i < 256; i++) begin
            idle();
            mem_a_addr = 8'(i);
            mem_b_addr = 6'(i);
            loom_shadow_addr = 11'(i * 8);
            loom_shadow_ren = 1'b1;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_test.md
Name: mem_test

Overview:
- Two-memory test block with independent functional ports, plus a unified shadow (debug/scan) port that reads and writes both arrays through one global byte-address map.
- mem_a: 8-bit x 256 words, held directly in mem_test.
- mem_b: 16-bit x 64 words, held in sub-instance u_mem_b containing SRAM instance u_sram.
- Serves as the end-to-end target for the memory-shadowing flow.

Parameters:
- SHADOW_AW, 11, shadow global byte-address width.
- SHADOW_DW, 16, shadow data width (max of all memory widths).
- MEM_B_BASE, 11'h000, mem_b base byte address (region size 0x100).
- MEM_A_BASE, 11'h100, mem_a base byte address (region size 0x400).

Ports:
- clk  in  1  single clock; all state and both port sets sample on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_a_we  in  1  mem_a write enable.
- mem_a_addr  in  8  mem_a word address.
- mem_a_wdata  in  8  mem_a write data.
- mem_a_rdata  out  8  mem_a registered read data.
- mem_b_we  in  1  mem_b write enable.
- mem_b_addr  in  6  mem_b word address.
- mem_b_wdata  in  16  mem_b write data.
- mem_b_rdata  out  16  mem_b registered read data.
- loom_shadow_addr  in  11  global byte address.
- loom_shadow_wdata  in  16  shadow write data.
- loom_shadow_rdata  out  16  shadow registered read data.
- loom_shadow_wen  in  1  shadow write strobe.
- loom_shadow_ren  in  1  shadow read strobe.
- There is no separate shadow clock; the shadow port runs on clk.

Behaviour:
- Reset:
  - mem_a_rdata, mem_b_rdata and loom_shadow_rdata reset to 0.
  - Array contents are not reset.
  - Reset asserted mid-operation aborts any pending read update and zeroes all rdata registers.
- Functional write: mem_X_we=1 at a rising edge writes mem_X_wdata to mem_X[addr] at that edge.
- Functional read:
  - Every rising edge registers mem_X[addr] into mem_X_rdata, regardless of we.
  - Latency is 1 cycle; data is valid the cycle after the address is presented.
  - Read-during-write to the same address returns the old data.
- Shadow decode (word index = (addr - base) >> 2; addr[1:0] ignored):
  - 0x000..0x0FF selects mem_b, index = addr[7:2].
  - 0x100..0x4FF selects mem_a, index = (addr - 0x100)[9:2].
  - 0x500..0x7FF is unmapped.
- Shadow write:
  - wen=1 writes wdata[W-1:0] into the selected word at the edge.
  - mem_a takes wdata[7:0]; upper bits are ignored.
  - A write to an unmapped address is dropped.
- Shadow read:
  - ren=1 at an edge loads the selected word, zero-extended to 16 bits, into loom_shadow_rdata; valid 1 cycle later.
  - loom_shadow_rdata holds its value while ren=0.
  - A read of an unmapped address loads 0.
- Same-cycle wen and ren: the write takes effect and rdata returns the old contents.
- Same-cycle functional write and shadow write to the same word: the shadow write wins. Writes to different words both complete.
- Functional and shadow reads may occur concurrently with no stall.

Optional Feature:
- Macro LOOM_SHADOW_EN.
- Defined: shadow port and decode logic are implemented as above.
- Undefined:
  - Shadow ports remain in the port list; inputs are ignored.
  - loom_shadow_rdata is tied to 0.
  - Arrays are reachable only through the functional ports.

Test Plan:
- Functional write mem_a[0x10]=0xAB, [0x20]=0xCD, [0x30]=0xEF -> shadow reads at 0x140, 0x180, 0x1C0 return 0x00AB, 0x00CD, 0x00EF.
- Shadow write 0x0012 to 0x200 and 0x0034 to 0x240 -> functional reads mem_a[0x40]=0x12 and mem_a[0x50]=0x34, one cycle latency.
- Functional write mem_b[0x0A]=0xDEAD, [0x0B]=0xBEEF -> shadow reads at 0x028 and 0x02C return 0xDEAD and 0xBEEF.
- Shadow write 0xCAFE to 0x0FC -> functional read mem_b[0x3F]=0xCAFE; mem_a[0x00] and mem_b[0x3E] are unchanged.
- Shadow write to 0x500 then shadow read at 0x500 -> rdata=0x0000, and no array is modified.
- Same-edge functional write mem_b[5]=0x1111 and shadow write 0x014=0x2222 -> mem_b[5]=0x2222. Assert rst_n mid-read -> all rdata=0.
